// File: rtl/cdb_scheduler_pkg.sv
// Shared constants and types for the CDB completion scheduler.
package cdb_scheduler_pkg;

  localparam int N             = 2;
  localparam int NUM_FU_ALU    = 3;
  localparam int NUM_FU_MULT   = 2;
  localparam int NUM_FU_BRANCH = 1;
  localparam int NUM_FU_LDST   = 1;
  localparam int NUM_FU_TOTAL  = NUM_FU_MULT + NUM_FU_ALU + NUM_FU_BRANCH + NUM_FU_LDST;

  // FU_IDX: column offsets inside one slot select, LSB first
  localparam int MULT_BASE   = 0;
  localparam int ALU_BASE    = MULT_BASE + NUM_FU_MULT;
  localparam int BRANCH_BASE = ALU_BASE + NUM_FU_ALU;
  localparam int LDST_BASE   = BRANCH_BASE + NUM_FU_BRANCH;

  // Holders are the multi-cycle units: mults first, then ldst
  localparam int NUM_HOLDERS = NUM_FU_MULT + NUM_FU_LDST;

  localparam int CNT_W      = $clog2(N + 1);
  localparam int ALU_PTR_W  = (NUM_FU_ALU > 1) ? $clog2(NUM_FU_ALU) : 1;
  localparam int AGE_W      = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = 4'hF;

  typedef logic [NUM_FU_TOTAL-1:0] fu_vec_t;
  typedef fu_vec_t [N-1:0] CDB_GNT_BUS;

  // Column of holder h in the slot select vector
  function automatic int holder_col(input int h);
    return (h < NUM_FU_MULT) ? (MULT_BASE + h) : (LDST_BASE + h - NUM_FU_MULT);
  endfunction

endpackage

// File: rtl/cdb_scheduler_if.sv
// Issue/completion handshake bundle between the execute stage and the scheduler.
interface cdb_scheduler_if import cdb_scheduler_pkg::*; ();

  logic [NUM_FU_ALU-1:0]    alu_req;
  logic [NUM_FU_BRANCH-1:0] branch_req;
  logic [NUM_FU_MULT-1:0]   mult_cdb_valid;
  logic [NUM_FU_LDST-1:0]   ldst_cdb_valid;
  logic [NUM_FU_ALU-1:0]    alu_issue_gnt;
  logic [NUM_FU_BRANCH-1:0] branch_issue_gnt;
  logic [NUM_FU_MULT-1:0]   mult_cdb_en;
  logic [NUM_FU_LDST-1:0]   ldst_cdb_en;
  CDB_GNT_BUS               complete_gnt_bus;

  modport master (
    output alu_req, branch_req, mult_cdb_valid, ldst_cdb_valid,
    input  alu_issue_gnt, branch_issue_gnt, mult_cdb_en, ldst_cdb_en, complete_gnt_bus
  );

  modport slave (
    input  alu_req, branch_req, mult_cdb_valid, ldst_cdb_valid,
    output alu_issue_gnt, branch_issue_gnt, mult_cdb_en, ldst_cdb_en, complete_gnt_bus
  );

endinterface

// File: rtl/cdb_scheduler_rr_pick.sv
// Rotating picker: grants up to 'budget' requesters starting at start_ptr.
module rr_pick #(
  parameter  int WIDTH = 3,
  parameter  int CNT_W = 2,
  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PTR_W-1:0] start_ptr,
  input  logic [CNT_W-1:0] budget,
  output logic [WIDTH-1:0] gnt,
  output logic [PTR_W-1:0] next_ptr
);

  // Walk requesters in rotating order; next_ptr lands one past the last grant
  always_comb begin : pick
    int taken;
    int idx;
    gnt      = '0;
    next_ptr = start_ptr;
    taken    = 0;
    idx      = 0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = (int'(start_ptr) + k) % WIDTH;
      for (int j = 0; j < WIDTH; j++) begin
        if ((j == idx) && req[j] && (taken < int'(budget))) begin
          gnt[j]   = 1'b1;
          taken    = taken + 1;
          next_ptr = PTR_W'((j + 1) % WIDTH);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_scheduler.sv
// Allocates the N CDB slots each cycle and registers the selects one cycle later.
module cdb_scheduler import cdb_scheduler_pkg::*; #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clock,
  input  logic           reset,
  cdb_scheduler_if.slave bus
);

  logic [NUM_HOLDERS-1:0] holder_valid;
  logic [NUM_HOLDERS-1:0] holder_elig;
  logic [NUM_HOLDERS-1:0] holder_urgent;
  logic [NUM_HOLDERS-1:0] holder_win;
  logic [NUM_HOLDERS-1:0] pend_q;
  logic [AGE_W-1:0]       age_q [NUM_HOLDERS];

  logic [NUM_FU_BRANCH-1:0] branch_win;
  logic [NUM_FU_ALU-1:0]    alu_win;
  logic [ALU_PTR_W-1:0]     rr_q;
  logic [ALU_PTR_W-1:0]     rr_next;
  logic [CNT_W-1:0]         hp_cnt;
  logic [CNT_W-1:0]         alu_budget;

  CDB_GNT_BUS gnt_hp;
  CDB_GNT_BUS gnt_d;
  CDB_GNT_BUS gnt_q;

  // A holder granted last cycle is masked so it never wins twice in a row
  assign holder_valid = {bus.ldst_cdb_valid, bus.mult_cdb_valid};
  assign holder_elig  = holder_valid & ~pend_q;

  // A holder becomes urgent once it has waited STARVE_LIMIT cycles
  always_comb begin
    for (int h = 0; h < NUM_HOLDERS; h++) begin
      holder_urgent[h] = (age_q[h] >= AGE_W'(STARVE_LIMIT));
    end
  end

  // Fill slots with urgent holders, then branch, then non-urgent holders
  always_comb begin : hp_pick
    int cnt;
    gnt_hp     = '0;
    holder_win = '0;
    branch_win = '0;
    cnt        = 0;
    for (int h = 0; h < NUM_HOLDERS; h++) begin
      if (holder_elig[h] && holder_urgent[h] && (cnt < N)) begin
        for (int s = 0; s < N; s++) begin
          if (s == cnt) gnt_hp[s] = gnt_hp[s] | (fu_vec_t'(1) << holder_col(h));
        end
        holder_win[h] = 1'b1;
        cnt = cnt + 1;
      end
    end
    for (int b = 0; b < NUM_FU_BRANCH; b++) begin
      if (bus.branch_req[b] && (cnt < N)) begin
        for (int s = 0; s < N; s++) begin
          if (s == cnt) gnt_hp[s] = gnt_hp[s] | (fu_vec_t'(1) << (BRANCH_BASE + b));
        end
        branch_win[b] = 1'b1;
        cnt = cnt + 1;
      end
    end
    for (int h = 0; h < NUM_HOLDERS; h++) begin
      if (holder_elig[h] && !holder_urgent[h] && (cnt < N)) begin
        for (int s = 0; s < N; s++) begin
          if (s == cnt) gnt_hp[s] = gnt_hp[s] | (fu_vec_t'(1) << holder_col(h));
        end
        holder_win[h] = 1'b1;
        cnt = cnt + 1;
      end
    end
    hp_cnt = CNT_W'(cnt);
  end

  // ALUs get whatever slots the higher-priority groups left over
  assign alu_budget = CNT_W'(N) - hp_cnt;

  rr_pick #(
    .WIDTH (NUM_FU_ALU),
    .CNT_W (CNT_W)
  ) u_alu_rr (
    .req       (bus.alu_req),
    .start_ptr (rr_q),
    .budget    (alu_budget),
    .gnt       (alu_win),
    .next_ptr  (rr_next)
  );

  // Append ALU winners after the other groups, in rotating order from rr_q
  always_comb begin : alu_place
    int cnt;
    int a;
    gnt_d = gnt_hp;
    cnt   = int'(hp_cnt);
    a     = 0;
    for (int k = 0; k < NUM_FU_ALU; k++) begin
      a = (int'(rr_q) + k) % NUM_FU_ALU;
      for (int j = 0; j < NUM_FU_ALU; j++) begin
        if ((j == a) && alu_win[j]) begin
          for (int s = 0; s < N; s++) begin
            if (s == cnt) gnt_d[s] = gnt_d[s] | (fu_vec_t'(1) << (ALU_BASE + j));
          end
          cnt = cnt + 1;
        end
      end
    end
  end

  assign bus.alu_issue_gnt    = reset ? '0 : alu_win;
  assign bus.branch_issue_gnt = reset ? '0 : branch_win;
  assign bus.complete_gnt_bus = gnt_q;
  assign bus.mult_cdb_en      = pend_q[NUM_FU_MULT-1:0];
  assign bus.ldst_cdb_en      = pend_q[NUM_HOLDERS-1:NUM_FU_MULT];

  // Register this cycle's slot selects and holder winners; reset discards them
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_q  <= '0;
      pend_q <= '0;
      rr_q   <= '0;
    end else begin
      gnt_q  <= gnt_d;
      pend_q <= holder_win;
      if (|alu_win) rr_q <= rr_next;
    end
  end

  // Age each holder while it waits with a valid result; clear on grant or idle
  always_ff @(posedge clock) begin
    for (int h = 0; h < NUM_HOLDERS; h++) begin
      if (reset || !holder_valid[h] || holder_win[h]) begin
        age_q[h] <= '0;
      end else if (age_q[h] != AGE_MAX) begin
        age_q[h] <= age_q[h] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_scheduler.sv
// Self-checking bench for cdb_scheduler: directed scenarios plus random traffic vs a model.
module tb_cdb_scheduler;
  import cdb_scheduler_pkg::*;

  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  cdb_scheduler_if sif ();

  cdb_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  // Reference model state: slot contents, pending holders, ages, ALU pointer
  fu_vec_t    m_slot [N];
  fu_vec_t    n_slot [N];
  bit         m_pend [NUM_HOLDERS];
  bit         n_pend [NUM_HOLDERS];
  int         m_age  [NUM_HOLDERS];
  int         n_age  [NUM_HOLDERS];
  int         m_rr, n_rr;
  logic [NUM_FU_ALU-1:0] e_alu;
  logic       e_br;
  CDB_GNT_BUS exp_bus;

  function automatic CDB_GNT_BUS pack_slots(input fu_vec_t sl [N]);
    CDB_GNT_BUS r;
    r = '0;
    for (int s = 0; s < N; s++) r = r | (CDB_GNT_BUS'(sl[s]) << (s * NUM_FU_TOTAL));
    return r;
  endfunction

  task automatic set_in(input logic [2:0] alu, input logic br, input logic [1:0] mv,
                        input logic lv, input logic rst);
    sif.alu_req        = alu;
    sif.branch_req     = br;
    sif.mult_cdb_valid = mv;
    sif.ldst_cdb_valid = lv;
    reset              = rst;
  endtask

  // Winners = first N of the priority-ordered list of ready columns
  task automatic model_eval();
    int win[$];
    int hv[NUM_HOLDERS];
    int ar[NUM_FU_ALU];
    int hc[NUM_HOLDERS];
    int used, c, h, a;
    hc[0] = 0; hc[1] = 1; hc[2] = 6;
    hv[0] = int'(sif.mult_cdb_valid[0]);
    hv[1] = int'(sif.mult_cdb_valid[1]);
    hv[2] = int'(sif.ldst_cdb_valid[0]);
    ar[0] = int'(sif.alu_req[0]);
    ar[1] = int'(sif.alu_req[1]);
    ar[2] = int'(sif.alu_req[2]);
    e_alu = '0;
    e_br  = 1'b0;
    n_rr  = m_rr;
    for (int s = 0; s < N; s++) n_slot[s] = '0;
    for (int i = 0; i < NUM_HOLDERS; i++) n_pend[i] = 1'b0;
    if (reset) begin
      n_rr = 0;
      for (int i = 0; i < NUM_HOLDERS; i++) n_age[i] = 0;
      return;
    end
    for (int i = 0; i < NUM_HOLDERS; i++)
      if (hv[i] != 0 && !m_pend[i] && m_age[i] >= LIMIT) win.push_back(hc[i]);
    if (sif.branch_req[0]) win.push_back(5);
    for (int i = 0; i < NUM_HOLDERS; i++)
      if (hv[i] != 0 && !m_pend[i] && m_age[i] < LIMIT) win.push_back(hc[i]);
    for (int k = 0; k < NUM_FU_ALU; k++) begin
      a = (m_rr + k) % NUM_FU_ALU;
      if (ar[a] != 0) win.push_back(2 + a);
    end
    used = (win.size() < N) ? win.size() : N;
    for (int s = 0; s < used; s++) begin
      c = win[s];
      n_slot[s] = fu_vec_t'(1) << c;
      if (c >= 2 && c <= 4) begin
        e_alu = e_alu | (3'b001 << (c - 2));
        n_rr  = (c - 2 + 1) % NUM_FU_ALU;
      end else if (c == 5) begin
        e_br = 1'b1;
      end else begin
        h = (c == 6) ? 2 : c;
        n_pend[h] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_HOLDERS; i++) begin
      if (hv[i] == 0 || n_pend[i]) n_age[i] = 0;
      else n_age[i] = (m_age[i] == 15) ? 15 : m_age[i] + 1;
    end
  endtask

  task automatic step_eval();
    model_eval();
    @(negedge clock);
  endtask

  task automatic step_commit();
    @(posedge clock);
    #1;
    m_pend  = n_pend;
    m_age   = n_age;
    m_rr    = n_rr;
    m_slot  = n_slot;
    exp_bus = pack_slots(m_slot);
  endtask

  task automatic reset_cycle();
    set_in(3'b000, 1'b0, 2'b00, 1'b0, 1'b1);
    step_eval();
    step_commit();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      set_in(3'b111, 1'b1, 2'b11, 1'b1, 1'b1);
      step_eval();
      total++;
      if (sif.alu_issue_gnt !== 3'b000) begin bad++; $display("[TB] FAIL reset_alu_gnt: got %b want 000", sif.alu_issue_gnt); end
      total++;
      if (sif.branch_issue_gnt !== 1'b0) begin bad++; $display("[TB] FAIL reset_br_gnt: got %b want 0", sif.branch_issue_gnt); end
      step_commit();
      total++;
      if (sif.complete_gnt_bus !== 14'b0) begin bad++; $display("[TB] FAIL reset_bus: got %b want 0", sif.complete_gnt_bus); end
      total++;
      if (sif.mult_cdb_en !== 2'b00) begin bad++; $display("[TB] FAIL reset_mult_en: got %b want 00", sif.mult_cdb_en); end
      total++;
      if (sif.ldst_cdb_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_ldst_en: got %b want 0", sif.ldst_cdb_en); end
    end
    set_in(3'b111, 1'b1, 2'b11, 1'b1, 1'b0);
    step_eval();
    total++;
    if (sif.complete_gnt_bus !== 14'b0) begin bad++; $display("[TB] FAIL release_bus: got %b want 0", sif.complete_gnt_bus); end
    total++;
    if (sif.mult_cdb_en !== 2'b00 || sif.ldst_cdb_en !== 1'b0) begin
      bad++; $display("[TB] FAIL release_en: got %b/%b want 00/0", sif.mult_cdb_en, sif.ldst_cdb_en);
    end
    step_commit();
  endtask

  task automatic test_alu_rr();
    reset_cycle();
    set_in(3'b111, 1'b0, 2'b00, 1'b0, 1'b0);
    step_eval();
    total++;
    if (sif.alu_issue_gnt !== 3'b011) begin bad++; $display("[TB] FAIL rr_gnt0: got %b want 011", sif.alu_issue_gnt); end
    step_commit();
    total++;
    if (sif.complete_gnt_bus !== {7'b0001000, 7'b0000100}) begin
      bad++; $display("[TB] FAIL rr_bus0: got %b want %b", sif.complete_gnt_bus, {7'b0001000, 7'b0000100});
    end
    total++;
    if (dut.rr_q !== 2'd2) begin bad++; $display("[TB] FAIL rr_ptr0: got %0d want 2", dut.rr_q); end
    step_eval();
    total++;
    if (sif.alu_issue_gnt !== 3'b101) begin bad++; $display("[TB] FAIL rr_gnt1: got %b want 101", sif.alu_issue_gnt); end
    step_commit();
    total++;
    if (sif.complete_gnt_bus !== {7'b0000100, 7'b0010000}) begin
      bad++; $display("[TB] FAIL rr_bus1: got %b want %b", sif.complete_gnt_bus, {7'b0000100, 7'b0010000});
    end
    total++;
    if (dut.rr_q !== 2'd1) begin bad++; $display("[TB] FAIL rr_ptr1: got %0d want 1", dut.rr_q); end
  endtask

  task automatic test_priority_mix();
    reset_cycle();
    set_in(3'b001, 1'b1, 2'b01, 1'b0, 1'b0);
    step_eval();
    total++;
    if (sif.alu_issue_gnt !== 3'b000) begin bad++; $display("[TB] FAIL mix_alu_gnt: got %b want 000", sif.alu_issue_gnt); end
    total++;
    if (sif.branch_issue_gnt !== 1'b1) begin bad++; $display("[TB] FAIL mix_br_gnt: got %b want 1", sif.branch_issue_gnt); end
    step_commit();
    total++;
    if (sif.complete_gnt_bus !== {7'b0000001, 7'b0100000}) begin
      bad++; $display("[TB] FAIL mix_bus: got %b want %b", sif.complete_gnt_bus, {7'b0000001, 7'b0100000});
    end
    total++;
    if (sif.mult_cdb_en !== 2'b01) begin bad++; $display("[TB] FAIL mix_mult_en: got %b want 01", sif.mult_cdb_en); end
  endtask

  task automatic test_no_regrant();
    logic [1:0] want [3];
    want[0] = 2'b01; want[1] = 2'b00; want[2] = 2'b01;
    reset_cycle();
    for (int c = 0; c < 3; c++) begin
      set_in(3'b000, 1'b0, 2'b01, 1'b0, 1'b0);
      step_eval();
      step_commit();
      total++;
      if (sif.mult_cdb_en !== want[c]) begin
        bad++; $display("[TB] FAIL noregrant_en%0d: got %b want %b", c, sif.mult_cdb_en, want[c]);
      end
      total++;
      if (sif.complete_gnt_bus !== ((want[c] == 2'b01) ? {7'b0, 7'b0000001} : 14'b0)) begin
        bad++; $display("[TB] FAIL noregrant_bus%0d: got %b", c, sif.complete_gnt_bus);
      end
    end
  endtask

  task automatic test_starvation();
    reset_cycle();
    set_in(3'b000, 1'b1, 2'b11, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step_eval();
      total++;
      if (dut.age_q[2] !== 4'(c)) begin bad++; $display("[TB] FAIL starve_age%0d: got %0d want %0d", c, dut.age_q[2], c); end
      step_commit();
      total++;
      if (sif.ldst_cdb_en !== ((c == 4) ? 1'b1 : 1'b0)) begin
        bad++; $display("[TB] FAIL starve_ldst_en%0d: got %b want %b", c, sif.ldst_cdb_en, (c == 4));
      end
    end
    total++;
    if (sif.complete_gnt_bus !== {7'b0100000, 7'b1000000}) begin
      bad++; $display("[TB] FAIL starve_bus: got %b want %b", sif.complete_gnt_bus, {7'b0100000, 7'b1000000});
    end
    total++;
    if (dut.age_q[2] !== 4'd0) begin bad++; $display("[TB] FAIL starve_clear: got %0d want 0", dut.age_q[2]); end
  endtask

  task automatic test_reset_mid();
    reset_cycle();
    set_in(3'b000, 1'b0, 2'b10, 1'b0, 1'b0);
    step_eval();
    step_commit();
    total++;
    if (sif.mult_cdb_en !== 2'b10) begin bad++; $display("[TB] FAIL mid_en_before: got %b want 10", sif.mult_cdb_en); end
    set_in(3'b011, 1'b1, 2'b10, 1'b0, 1'b1);
    step_eval();
    total++;
    if (sif.alu_issue_gnt !== 3'b000 || sif.branch_issue_gnt !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_issue: got %b/%b want 000/0", sif.alu_issue_gnt, sif.branch_issue_gnt);
    end
    step_commit();
    total++;
    if (sif.mult_cdb_en !== 2'b00) begin bad++; $display("[TB] FAIL mid_en_after: got %b want 00", sif.mult_cdb_en); end
    total++;
    if (sif.complete_gnt_bus !== 14'b0) begin bad++; $display("[TB] FAIL mid_bus: got %b want 0", sif.complete_gnt_bus); end
  endtask

  task automatic test_random();
    reset_cycle();
    for (int c = 0; c < 400; c++) begin
      set_in(3'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0));
      step_eval();
      total++;
      if (sif.alu_issue_gnt !== e_alu || sif.branch_issue_gnt !== e_br) begin
        bad++; $display("[TB] FAIL rand_issue@%0d: got %b/%b want %b/%b", c, sif.alu_issue_gnt, sif.branch_issue_gnt, e_alu, e_br);
      end
      step_commit();
      total++;
      if (sif.complete_gnt_bus !== exp_bus) begin
        bad++; $display("[TB] FAIL rand_bus@%0d: got %b want %b", c, sif.complete_gnt_bus, exp_bus);
      end
      total++;
      if (sif.mult_cdb_en !== {m_pend[1], m_pend[0]} || sif.ldst_cdb_en !== m_pend[2]) begin
        bad++; $display("[TB] FAIL rand_en@%0d: got %b/%b want %b%b/%b", c, sif.mult_cdb_en, sif.ldst_cdb_en, m_pend[1], m_pend[0], m_pend[2]);
      end
    end
  endtask

  initial begin
    m_rr = 0;
    for (int i = 0; i < NUM_HOLDERS; i++) begin
      m_pend[i] = 1'b0;
      m_age[i]  = 0;
    end
    for (int s = 0; s < N; s++) m_slot[s] = '0;
    exp_bus = '0;
    set_in(3'b000, 1'b0, 2'b00, 1'b0, 1'b1);
    test_reset();
    test_alu_rr();
    test_priority_mix();
    test_no_regrant();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
